// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
// Read-address tracking is built only with SPI_RD_ADDR_TRACK_EN.
package spi_pkg;

  localparam int DEF_DATA_W = 8;

  function automatic int frame_w(input int dw);
    return dw + 2;
  endfunction

  localparam int FRAME_W = frame_w(DEF_DATA_W);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    HOLD,
    TX
  } spi_state_e;

endpackage

// File: rtl/spi_shift_out.sv
// Parallel-load, MSB-first serialiser driving MISO.
// Idle output is 0; clear drops any byte in flight.
module spi_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sout
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        sh  <= '0;
        cnt <= '0;
      end else if (load) begin
        sh  <= data;
        cnt <= CW'(DATA_W);
      end else if (cnt != '0) begin
        sh   <= {sh[DATA_W-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
        done <= (cnt == CW'(1));
      end
    end
  end

  assign busy = (cnt != '0);
  assign sout = busy & sh[DATA_W-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front-end: MOSI frames to RAM commands, RAM read byte to MISO.
// Define SPI_RD_ADDR_TRACK_EN to split reads by the rd_addr_seen flag.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int FW = frame_w(DATA_W);
  localparam int CW = $clog2(FW + 1);

  spi_state_e  state;
  logic [CW-1:0] bit_cnt;
  logic        loaded;
  logic        abort;
  logic        load;
  logic        busy;
  logic        done;
  logic [FW-1:0] frame_nxt;

`ifdef SPI_RD_ADDR_TRACK_EN
  logic        rd_addr_seen;
`endif

  assign abort     = SS_n && (state != IDLE);
  assign frame_nxt = {rx_data[FW-2:0], MOSI};
  // rx_valid high means the RAM has not yet answered; its old level is stale
  assign load = (state == TX) && !loaded && !busy
             && tx_valid && !rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      loaded   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`ifdef SPI_RD_ADDR_TRACK_EN
      rd_addr_seen <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
        loaded  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state   <= CHK_CMD;
              bit_cnt <= '0;
            end
          end
          CHK_CMD: begin
            if (!MOSI) begin
              state <= WRITE;
            end else begin
`ifdef SPI_RD_ADDR_TRACK_EN
              state <= rd_addr_seen ? READ_DATA : READ_ADD;
`else
              state <= READ_ADD;
`endif
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_data <= frame_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(FW - 1)) begin
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              state    <= HOLD;
`ifdef SPI_RD_ADDR_TRACK_EN
              if (state == READ_ADD) begin
                rd_addr_seen <= 1'b1;
              end
              if (state == READ_DATA) begin
                rd_addr_seen <= 1'b0;
                state        <= TX;
              end
`else
              if (frame_nxt[FW-1 -: 2] == CMD_RD_DATA) begin
                state <= TX;
              end
`endif
            end
          end
          TX: begin
            if (load) begin
              loaded <= 1'b1;
            end
            if (done) begin
              state <= HOLD;
            end
          end
          HOLD: begin
            state <= HOLD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  spi_shift_out #(
    .DATA_W(DATA_W)
  ) u_shift_out (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(abort),
    .load (load),
    .data (tx_data),
    .busy (busy),
    .done (done),
    .sout (MISO)
  );

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: frame table plus read/abort/reset
// sequences, with a queue scoreboard on rx_data.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;

  int checks = 0;
  int passes = 0;
  int rx_pulses = 0;
  int miso_high = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;

  typedef struct {
    logic       dec;
    logic [9:0] fr;
    int         nbits;
    int         extra;
    int         exp_pulses;
    string      nm;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  spi_slave_fsm #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (MISO === 1'b1) miso_high++;
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rx_unexpected: got rx_data %0h, required no rx_valid",
                 rx_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(exp_w));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic dec, input logic [9:0] fr,
                             input int nbits);
    if (nbits == 10) exp_q.push_back(fr);
    SS_n = 1'b0;
    tick();
    MOSI = dec;
    tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = fr[9-i];
      tick();
    end
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr_frame(input logic dec, input logic [9:0] fr,
                          input int nbits, input int extra,
                          input int exp_p, input string nm);
    int p0;
    int m0;
    p0 = rx_pulses;
    m0 = miso_high;
    start_frame(dec, fr, nbits);
    for (int i = 0; i < extra; i++) begin
      MOSI = 1'($urandom);
      tick();
    end
    if (nbits < 10) begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
      chk({nm, "_idle"}, 32'(dut.state), 32'(IDLE));
      tick();
    end else begin
      end_frame();
    end
    chk({nm, "_pulses"}, rx_pulses - p0, exp_p);
    chk({nm, "_miso_quiet"}, miso_high - m0, 0);
  endtask

  task automatic rd_data(input logic [9:0] fr, input logic [7:0] txd,
                         input int hold, input int rst_at,
                         input string nm);
    int p0;
    int tvc;
    p0 = rx_pulses;
    start_frame(1'b1, fr, 10);
    tick();
    chk({nm, "_pre_latch"}, MISO, 0);
    tx_data  = txd;
    tx_valid = 1'b1;
    tvc = 1;
    for (int k = 7; k >= 0; k--) begin
      tick();
      if (++tvc > hold) tx_valid = 1'b0;
      chk({nm, "_miso_bit"}, MISO, txd[k]);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_rst_miso"}, MISO, 0);
        chk({nm, "_rst_rx_valid"}, rx_valid, 0);
        chk({nm, "_rst_rx_data"}, 32'(rx_data), 0);
        tx_valid = 1'b0;
        SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk({nm, "_rst_idle"}, 32'(dut.state), 32'(IDLE));
`ifdef SPI_RD_ADDR_TRACK_EN
        chk({nm, "_rst_seen"}, dut.rd_addr_seen, 0);
`endif
        chk({nm, "_rst_miso_after"}, MISO, 0);
        return;
      end
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      if (++tvc > hold) tx_valid = 1'b0;
      chk({nm, "_tail_zero"}, MISO, 0);
    end
    tx_valid = 1'b0;
    end_frame();
    chk({nm, "_pulses"}, rx_pulses - p0, 1);
  endtask

  initial begin
    tbl[0] = '{dec: 1'b0, fr: 10'h05A, nbits: 10, extra: 0,
               exp_pulses: 1, nm: "wr_addr"};
    tbl[1] = '{dec: 1'b0, fr: 10'h1A5, nbits: 10, extra: 3,
               exp_pulses: 1, nm: "wr_data"};
    tbl[2] = '{dec: 1'b0, fr: 10'h0FF, nbits: 5, extra: 0,
               exp_pulses: 0, nm: "abort"};
    tbl[3] = '{dec: 1'b0, fr: 10'h05A, nbits: 10, extra: 0,
               exp_pulses: 1, nm: "wr_after_abort"};
    tbl[4] = '{dec: 1'b0, fr: 10'h155, nbits: 10, extra: 1,
               exp_pulses: 1, nm: "wr_data_155"};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_miso", MISO, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
`ifdef SPI_RD_ADDR_TRACK_EN
    chk("reset_seen", dut.rd_addr_seen, 0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      wr_frame(tbl[i].dec, tbl[i].fr, tbl[i].nbits, tbl[i].extra,
               tbl[i].exp_pulses, tbl[i].nm);
    end

    wr_frame(1'b1, 10'h233, 10, 2, 1, "rd_addr");
`ifdef SPI_RD_ADDR_TRACK_EN
    chk("rd_addr_seen_set", dut.rd_addr_seen, 1);
`endif
    wr_frame(1'b0, 10'h1A5, 10, 0, 1, "wr_data_keep");
`ifdef SPI_RD_ADDR_TRACK_EN
    chk("wr_keeps_seen", dut.rd_addr_seen, 1);
`endif
    rd_data(10'h3A7, 8'hC3, 5, -1, "rd_c3");
`ifdef SPI_RD_ADDR_TRACK_EN
    chk("rd_data_clears_seen", dut.rd_addr_seen, 0);
`endif

    // stale tx_valid level held across the address frame and rx_valid
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wr_frame(1'b1, 10'h2F0, 10, 0, 1, "rd_addr_stale");
    rd_data(10'h35A, 8'h96, 1000, -1, "rd_stale");

    wr_frame(1'b1, 10'h211, 10, 0, 1, "rd_addr3");
    rd_data(10'h300, 8'h3C, 5, 3, "rd_rst");

    wr_frame(1'b1, 10'h2AA, 10, 0, 1, "rd_addr4");
    start_frame(1'b1, 10'h3FF, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_rst_idle", 32'(dut.state), 32'(IDLE));
`ifdef SPI_RD_ADDR_TRACK_EN
    chk("midframe_rst_seen", dut.rd_addr_seen, 0);
`endif
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    wr_frame(1'b0, 10'h0C3, 10, 0, 1, "wr_post_rst");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

SPI slave front-end of the SPI wrapper, sitting directly upstream of the single-port RAM. It deserialises MOSI frames into 10-bit command words (`rx_data` / `rx_valid`) for the RAM, and serialises the RAM's read byte (`tx_data` / `tx_valid`) back out on MISO. Bus sampling is synchronous to the system clock (one bit per `clk`); no separate SCK domain.

## Interface
- `DATA_W`, default 8: RAM data/address width; frame width is `DATA_W+2`.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `SS_n`  in  1: slave select, active low; high aborts/ends a frame.
- `MOSI`  in  1: serial data in, MSB first.
- `MISO`  out  1: serial data out, MSB first.
- `rx_data`  out  DATA_W+2: command word to RAM, `[9:8]` = command, `[7:0]` = address/data.
- `rx_valid`  out  1: one-cycle strobe, `rx_data` valid.
- `tx_data`  in  DATA_W: read byte from RAM.
- `tx_valid`  in  1: `tx_data` valid. Level, not a pulse: the RAM holds it until its next `rx_valid`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n` low at an edge -> CHK_CMD.
- CHK_CMD: MOSI sampled as the decision bit and not stored.
  - 0 -> WRITE.
  - 1 -> READ_ADD if `rd_addr_seen`=0, else READ_DATA.
- WRITE / READ_ADD / READ_DATA: the next 10 MOSI bits shift into `rx_data`, MSB first. The host repeats the decision bit as bit 9.
- After the 10th bit, `rx_valid` pulses for exactly 1 cycle and `rx_data` holds the frame.
- READ_ADD frame completion sets `rd_addr_seen`. READ_DATA frame completion clears it. Aborted frames leave it unchanged.
- READ_DATA return path:
  - After `rx_valid`, the first cycle with `tx_valid`=1 latches `tx_data` into the output shifter.
  - A `loaded` flag blocks re-latching on the held `tx_valid` level.
  - MISO then drives bits 7..0, one per cycle.
  - After bit 0, the FSM holds MISO=0 until `SS_n` goes high.
- WRITE / READ_ADD: after `rx_valid`, wait for `SS_n` high; extra MOSI bits are ignored.
- `SS_n` high in any non-IDLE state -> IDLE next cycle; bit counter, `loaded` and shifter are cleared; no `rx_valid` is emitted.
- `tx_valid` never arrives in READ_DATA: wait indefinitely with MISO=0 until `SS_n` high.
- `tx_valid` high outside READ_DATA: ignored.
- Async reset (including mid-frame) takes effect immediately: state IDLE, `MISO`=0, `rx_valid`=0, `rx_data`=0, `rd_addr_seen`=0, counters 0.

## Timing
- `SS_n` falls before edge E0 -> CHK_CMD samples the decision bit at E1.
- Data bits are sampled at E2..E11.
- `rx_valid`=1 in the cycle after E11.
- RAM latency is 1 cycle: `tx_valid` is seen one cycle after `rx_valid`.
- MISO bit 7 is valid the cycle after the latch; bit 0 is 7 cycles later.
- Frame-to-MISO-first-bit latency: 3 cycles after E11.
- Back-to-back frames need `SS_n` high for at least 1 cycle.

## Configuration
- `SPI_RD_ADDR_TRACK_EN` defined: read-path selection uses `rd_addr_seen` as above (READ_ADD / READ_DATA states).
- Not defined:
  - READ_ADD and READ_DATA collapse into a single read state and `rd_addr_seen` is not built.
  - After 10 bits, `rx_data[9:8]`=2'b11 enters the MISO return path; any other value ends the frame like a write.

## Structure
- `spi_pkg`:
  - state enum;
  - command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - `FRAME_W` = `DATA_W+2`.
- One sub-module, `spi_shift_out`:
  - parallel-load, MSB-first serialiser;
  - ports: load, `data[DATA_W-1:0]`, `busy`, `done`, `sout`.
- Deserialiser, counter and FSM live in the top module.

## Test plan
- Write address: `SS_n`=0, MOSI 0 then `00_0101_1010` -> single `rx_valid` pulse, `rx_data`=10'h05A, MISO stays 0.
- Write data: MOSI 0 then `01_1010_0101` -> `rx_data`=10'h1A5, one `rx_valid`, `rd_addr_seen` unchanged.
- Read address: MOSI 1 then `10_0011_0011` -> `rx_data`=10'h233, `rd_addr_seen`=1. Next read frame enters READ_DATA (with macro).
- Read data: MOSI 1 then `11_xxxx_xxxx`; respond `tx_data`=8'hC3 with `tx_valid` held high 5 cycles.
  - Required: MISO = 1,1,0,0,0,0,1,1 exactly once, then 0.
  - Required: `rd_addr_seen` cleared.
- Abort: `SS_n` high after 5 data bits -> IDLE next cycle, no `rx_valid`. The following full write frame decodes correctly.
- Reset mid-read: assert `rst_n`=0 during MISO bit 3 -> MISO=0 and `rx_valid`=0 immediately (asynchronous), IDLE on release, `rd_addr_seen`=0.
